// File: rtl/ldst_mmio_bridge.sv
// ---------------------------------------------------------------------------
// ldst_mmio_bridge
//
// Sits behind the CPU load/store port. It steers each access either to the
// external data RAM or to a small bank of on-chip MMIO registers. Both targets
// return read data with a fixed one-cycle latency, so the CPU never stalls.
//
// MMIO window: addr[15:8] == MMIO_BASE[15:8]. Register offsets (addr[7:0]):
//   00 LEDR      rw  drives o_ledr
//   02 HEX       rw  drives o_hex (four display nibbles)
//   04 SW        ro  two-flop synchronised i_sw, zero-extended
//   06 CYCLE     r   free-running counter; any write clears it
//   08 TMR_LOAD  w   loads countdown timer; read returns the current count
//   0A TMR_STAT  r   bit0 = expired flag; writing bit0=1 clears the flag
//   0C BUSERR    r   bit0 = o_bus_err (only when MMIO_BUSERR_EN is defined)
// Any other offset reads 0 and ignores writes.
//
// Optional feature macro: MMIO_BUSERR_EN
//   defined   : unmapped MMIO accesses set the sticky o_bus_err flag
//   undefined : o_bus_err is tied low and offset 0C is unmapped
//
// Ports
//   clk, reset            clock; asynchronous active-low reset
//   i_ldst_addr/rd/wr     CPU access (single-cycle strobes)
//   i_ldst_wrdata         CPU write data
//   o_ldst_rddata         read data, valid the cycle after an accepted read
//   o_mem_addr/rd/wr      RAM control (combinational)
//   o_mem_wrdata          RAM write data (pass-through)
//   i_mem_rddata          RAM read data, one cycle after o_mem_rd
//   i_sw                  asynchronous switches
//   o_ledr, o_hex         LED and HEX registers
//   o_tmr_irq             sticky timer-expired flag
//   o_bus_err             sticky unmapped-access flag
// ---------------------------------------------------------------------------
module ldst_mmio_bridge #(
    parameter logic [15:0] MMIO_BASE = 16'hA000,
    parameter int          LED_W     = 10,
    parameter int          SW_W      = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [15:0]      i_ldst_addr,
    input  logic             i_ldst_rd,
    input  logic             i_ldst_wr,
    input  logic [15:0]      i_ldst_wrdata,
    output logic [15:0]      o_ldst_rddata,
    output logic [15:0]      o_mem_addr,
    output logic             o_mem_rd,
    output logic             o_mem_wr,
    output logic [15:0]      o_mem_wrdata,
    input  logic [15:0]      i_mem_rddata,
    input  logic [SW_W-1:0]  i_sw,
    output logic [LED_W-1:0] o_ledr,
    output logic [15:0]      o_hex,
    output logic             o_tmr_irq,
    output logic             o_bus_err
);

    localparam logic [7:0] OFF_LEDR  = 8'h00;
    localparam logic [7:0] OFF_HEX   = 8'h02;
    localparam logic [7:0] OFF_SW    = 8'h04;
    localparam logic [7:0] OFF_CYCLE = 8'h06;
    localparam logic [7:0] OFF_TLOAD = 8'h08;
    localparam logic [7:0] OFF_TSTAT = 8'h0A;
`ifdef MMIO_BUSERR_EN
    localparam logic [7:0] OFF_BERR  = 8'h0C;
`endif

    typedef enum logic {
        TMR_IDLE = 1'b0,
        TMR_RUN  = 1'b1
    } tmr_state_t;

    logic             mmio_hit;
    logic [7:0]       offset;
    logic             mmio_wr;
    logic             rd_accept;
    logic [15:0]      mmio_rdval;

    logic [LED_W-1:0] led_q;
    logic [15:0]      hex_q;
    logic [SW_W-1:0]  sw_meta;
    logic [SW_W-1:0]  sw_sync;
    logic [15:0]      cycle_q;

    tmr_state_t       tmr_state_q, tmr_state_d;
    logic [15:0]      tmr_q, tmr_d;
    logic             irq_q, irq_d;
    logic             tmr_load;
    logic             stat_clr;

    logic             rd_valid_q;
    logic             src_sel_q;
    logic [15:0]      mmio_q;
    logic [15:0]      rddata_hold_q;

    assign mmio_hit  = (i_ldst_addr[15:8] == MMIO_BASE[15:8]);
    assign offset    = i_ldst_addr[7:0];
    assign mmio_wr   = i_ldst_wr & mmio_hit;
    // A simultaneous write takes priority and the read is dropped.
    assign rd_accept = i_ldst_rd & ~i_ldst_wr;

    assign o_mem_addr   = i_ldst_addr;
    assign o_mem_wrdata = i_ldst_wrdata;
    assign o_mem_rd     = i_ldst_rd & ~mmio_hit & ~i_ldst_wr;
    assign o_mem_wr     = i_ldst_wr & ~mmio_hit;

    assign tmr_load = mmio_wr && (offset == OFF_TLOAD);
    assign stat_clr = mmio_wr && (offset == OFF_TSTAT) && i_ldst_wrdata[0];

    // MMIO read mux. CYCLE returns the value the counter holds in the cycle
    // the data is presented, so a read right after a clearing write sees 1.
    always_comb begin
        mmio_rdval = 16'h0000;
        case (offset)
            OFF_LEDR:  mmio_rdval = 16'(led_q);
            OFF_HEX:   mmio_rdval = hex_q;
            OFF_SW:    mmio_rdval = 16'(sw_sync);
            OFF_CYCLE: mmio_rdval = cycle_q + 16'd1;
            OFF_TLOAD: mmio_rdval = tmr_q;
            OFF_TSTAT: mmio_rdval = {15'b0, irq_q};
`ifdef MMIO_BUSERR_EN
            OFF_BERR:  mmio_rdval = {15'b0, o_bus_err};
`endif
            default:   mmio_rdval = 16'h0000;
        endcase
    end

    // Writable display registers and the switch synchroniser.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led_q   <= '0;
            hex_q   <= '0;
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= i_sw;
            sw_sync <= sw_meta;
            if (mmio_wr && (offset == OFF_LEDR))
                led_q <= i_ldst_wrdata[LED_W-1:0];
            if (mmio_wr && (offset == OFF_HEX))
                hex_q <= i_ldst_wrdata;
        end
    end

    // Free-running cycle counter; a write in the same cycle wins over the
    // increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cycle_q <= '0;
        else if (mmio_wr && (offset == OFF_CYCLE))
            cycle_q <= '0;
        else
            cycle_q <= cycle_q + 16'd1;
    end

    // Countdown timer. A load always wins, so a load landing on the 1->0
    // step restarts the timer without raising the flag. Expiry beats a
    // same-cycle STAT clear because the set is applied last.
    always_comb begin
        tmr_state_d = tmr_state_q;
        tmr_d       = tmr_q;
        irq_d       = irq_q;
        if (stat_clr)
            irq_d = 1'b0;
        if (tmr_load) begin
            tmr_d       = i_ldst_wrdata;
            tmr_state_d = (i_ldst_wrdata != 16'h0000) ? TMR_RUN : TMR_IDLE;
        end else if (tmr_state_q == TMR_RUN) begin
            tmr_d = tmr_q - 16'd1;
            if (tmr_q == 16'd1) begin
                tmr_state_d = TMR_IDLE;
                irq_d       = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmr_state_q <= TMR_IDLE;
            tmr_q       <= '0;
            irq_q       <= 1'b0;
        end else begin
            tmr_state_q <= tmr_state_d;
            tmr_q       <= tmr_d;
            irq_q       <= irq_d;
        end
    end

    // Read pipeline: capture source and MMIO value on the accepted read,
    // present them next cycle, otherwise keep showing the last value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_valid_q    <= 1'b0;
            src_sel_q     <= 1'b0;
            mmio_q        <= '0;
            rddata_hold_q <= '0;
        end else begin
            rd_valid_q    <= rd_accept;
            rddata_hold_q <= o_ldst_rddata;
            if (rd_accept) begin
                src_sel_q <= mmio_hit;
                mmio_q    <= mmio_rdval;
            end
        end
    end

    assign o_ldst_rddata = rd_valid_q ? (src_sel_q ? mmio_q : i_mem_rddata)
                                      : rddata_hold_q;

`ifdef MMIO_BUSERR_EN
    logic offset_mapped;
    logic bus_err_q;

    assign offset_mapped = offset inside {OFF_LEDR, OFF_HEX, OFF_SW, OFF_CYCLE,
                                          OFF_TLOAD, OFF_TSTAT, OFF_BERR};

    // Sticky until reset; any read or write to a hole in the window sets it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            bus_err_q <= 1'b0;
        else if (mmio_hit && (i_ldst_rd || i_ldst_wr) && !offset_mapped)
            bus_err_q <= 1'b1;
    end

    assign o_bus_err = bus_err_q;
`else
    assign o_bus_err = 1'b0;
`endif

    assign o_ledr    = led_q;
    assign o_hex     = hex_q;
    assign o_tmr_irq = irq_q;

endmodule
